// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Imported by mem_arbiter and arb_lat_cnt.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int LATENCY_DEF    = 4;
  localparam int STARVE_MAX_DEF = 2;
  localparam int CNT_W          = 4;
  localparam int STV_W          = 8;

endpackage

// File: rtl/arb_lat_cnt.sv
// Memory-latency down-counter: load on access start,
// count down while busy, flag zero on the last busy cycle.
module arb_lat_cnt
  import mem_arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // load wins over decrement; stop at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared
// memory with fixed latency and bounded fetch starvation.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY    = LATENCY_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ack,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LAT_LD =
    CNT_W'(LATENCY - 1);
  localparam logic [STV_W-1:0] STV_LIM =
    STV_W'(STARVE_MAX);

  state_t             r_state;
  state_t             w_next;
  owner_t             r_own;
  logic               r_wr;
  logic               r_first;
  logic [15:0]        r_addr;
  logic [15:0]        r_wdata;
  logic [15:0]        r_irdata;
  logic [15:0]        r_drdata;
  logic [STV_W-1:0]   r_starve;
  logic               w_any;
  logic               w_gnt_i;
  logic               w_start;
  logic               w_finish;
  logic               w_zero;

  assign w_any    = i_req | d_req;
  // fetch wins when alone, or when data has had its quota
  assign w_gnt_i  = i_req &
                    (~d_req | (r_starve == STV_LIM));
  assign w_start  = (r_state == ST_IDLE) & w_any;
  assign w_finish = (r_state == ST_BUSY) & w_zero;

  arb_lat_cnt #(.W(CNT_W)) u_lat (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_start),
    .i_dec  (r_state == ST_BUSY),
    .i_val  (LAT_LD),
    .o_zero (w_zero)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any)  w_next = ST_BUSY;
      ST_BUSY: if (w_zero) w_next = ST_DONE;
      ST_DONE:             w_next = ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
  end

  // outputs decoded from state and latched request
  always_comb begin
    busy      = (r_state != ST_IDLE);
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    if (r_state == ST_BUSY) begin
      mem_en    = r_first;
      mem_wr    = r_wr;
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
    end
    if (r_state == ST_DONE) begin
      i_ack = (r_own == OWN_I);
      d_ack = (r_own == OWN_D);
    end
  end

  // latch the granted request on access start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own   <= OWN_I;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_first <= 1'b0;
    end else begin
      r_first <= w_start;
      if (w_start) begin
        r_own   <= w_gnt_i ? OWN_I : OWN_D;
        r_wr    <= ~w_gnt_i & d_wr;
        r_addr  <= w_gnt_i ? i_addr : d_addr;
        r_wdata <= w_gnt_i ? '0 : d_wdata;
      end
    end
  end

  // count data grants that made a fetch wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (w_start) begin
      if (w_gnt_i)    r_starve <= '0;
      else if (i_req) r_starve <= r_starve + 1'b1;
    end
  end

  // capture read data into the owner's register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irdata <= '0;
      r_drdata <= '0;
    end else if (w_finish && !r_wr) begin
      if (r_own == OWN_I) r_irdata <= mem_rdata;
      else                r_drdata <= mem_rdata;
    end
  end

  assign i_rdata = r_irdata;
  assign d_rdata = r_drdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a
// transaction-level reference model checked every cycle.
module tb_mem_arbiter;

  localparam int L    = 4;
  localparam int SMAX = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_ack;
  logic [15:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(L), .STARVE_MAX(SMAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: one outstanding access described by the
  // number of cycles k since its grant cycle
  bit          m_act = 1'b0;
  int          m_k = 0;
  bit          m_own = 1'b0;
  bit          m_wr = 1'b0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_ird = '0;
  logic [15:0] m_drd = '0;
  int          m_starve = 0;
  bit          e_mem;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0;
      m_starve = 0;
      m_ird = '0;
      m_drd = '0;
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_en", 16'(mem_en), 16'd0);
      chk("rst_wr", 16'(mem_wr), 16'd0);
      chk("rst_addr", mem_addr, 16'd0);
      chk("rst_wdata", mem_wdata, 16'd0);
      chk("rst_iack", 16'(i_ack), 16'd0);
      chk("rst_dack", 16'(d_ack), 16'd0);
      chk("rst_irdata", i_rdata, 16'd0);
      chk("rst_drdata", d_rdata, 16'd0);
    end else begin
      if (m_act) m_k++;
      e_mem = m_act && (m_k <= L);
      chk("m_busy", 16'(busy), 16'(m_act));
      chk("m_en", 16'(mem_en), 16'(m_act && m_k == 1));
      chk("m_wr", 16'(mem_wr), 16'(e_mem && m_wr));
      chk("m_addr", mem_addr, e_mem ? m_addr : 16'd0);
      chk("m_wdata", mem_wdata, e_mem ? m_wdata : 16'd0);
      chk("m_iack", 16'(i_ack),
          16'(m_act && m_k == L + 1 && !m_own));
      chk("m_dack", 16'(d_ack),
          16'(m_act && m_k == L + 1 && m_own));
      chk("m_excl", 16'(i_ack & d_ack), 16'd0);
      chk("m_irdata", i_rdata, m_ird);
      chk("m_drdata", d_rdata, m_drd);
      if (m_act && m_k == L && !m_wr) begin
        if (m_own) m_drd = mem_rdata;
        else       m_ird = mem_rdata;
      end
      if (m_act && m_k == L + 1) begin
        m_act = 1'b0;
      end else if (!m_act && (i_req || d_req)) begin
        m_own = d_req && !(i_req && m_starve == SMAX);
        if (!m_own)     m_starve = 0;
        else if (i_req) m_starve++;
        m_addr  = m_own ? d_addr : i_addr;
        m_wr    = m_own && d_wr;
        m_wdata = m_own ? d_wdata : 16'd0;
        m_act   = 1'b1;
        m_k     = 0;
      end
    end
  end

  bit exp_ord[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  bit got_ord[6];
  int nacks;
  int dacks;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("r_busy", 16'(busy), 16'd0);
    chk("r_iack", 16'(i_ack), 16'd0);
    chk("r_irdata", i_rdata, 16'd0);
    rst_n = 1'b1;

    // single fetch
    i_req = 1'b1;
    i_addr = 16'h0010;
    tick;
    chk("f_en1", 16'(mem_en), 16'd1);
    chk("f_addr", mem_addr, 16'h0010);
    chk("f_wr", 16'(mem_wr), 16'd0);
    tick;
    chk("f_en2", 16'(mem_en), 16'd0);
    tick;
    tick;
    mem_rdata = 16'hA5A5;
    chk("f_busy4", 16'(busy), 16'd1);
    tick;
    chk("f_ack", 16'(i_ack), 16'd1);
    chk("f_rdata", i_rdata, 16'hA5A5);
    i_req = 1'b0;
    tick;
    chk("f_idle", 16'(busy), 16'd0);

    // single store
    d_req = 1'b1;
    d_wr = 1'b1;
    d_addr = 16'h0200;
    d_wdata = 16'h1234;
    for (int k = 1; k <= L; k++) begin
      tick;
      mem_rdata = 16'(16'h7700 + k);
      chk("s_wr", 16'(mem_wr), 16'd1);
      chk("s_addr", mem_addr, 16'h0200);
      chk("s_wdata", mem_wdata, 16'h1234);
      chk("s_en", 16'(mem_en), 16'(k == 1));
    end
    tick;
    chk("s_ack", 16'(d_ack), 16'd1);
    chk("s_rdata", d_rdata, 16'd0);
    d_req = 1'b0;
    d_wr = 1'b0;
    tick;

    // contention: both held high
    i_req = 1'b1;
    i_addr = 16'h0100;
    d_req = 1'b1;
    d_addr = 16'h0400;
    nacks = 0;
    for (int c = 0; c < 80 && nacks < 6; c++) begin
      tick;
      mem_rdata = 16'($urandom);
      if (i_ack || d_ack) begin
        got_ord[nacks] = d_ack;
        nacks++;
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("c_count", 16'(nacks), 16'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("c_order%0d", i),
          16'(got_ord[i]), 16'(exp_ord[i]));
    tick;

    // reset during a load
    d_req = 1'b1;
    d_wr = 1'b0;
    d_addr = 16'h0300;
    tick;
    mem_rdata = 16'hBEEF;
    chk("a_en", 16'(mem_en), 16'd1);
    tick;
    rst_n = 1'b0;
    #1;
    chk("a_busy", 16'(busy), 16'd0);
    chk("a_en0", 16'(mem_en), 16'd0);
    chk("a_addr", mem_addr, 16'd0);
    d_req = 1'b0;
    tick;
    rst_n = 1'b1;
    dacks = 0;
    for (int c = 0; c < 8; c++) begin
      tick;
      if (d_ack) dacks++;
    end
    chk("a_noack", 16'(dacks), 16'd0);
    chk("a_drdata", d_rdata, 16'd0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      tick;
      mem_rdata = 16'($urandom);
      if (i_req) begin
        if (i_ack) begin
          i_req = 1'($urandom_range(0, 1));
          i_addr = 16'($urandom);
        end
      end else if ($urandom_range(0, 2) == 0) begin
        i_req = 1'b1;
        i_addr = 16'($urandom);
      end
      if (d_req) begin
        if (d_ack) begin
          d_req = 1'($urandom_range(0, 1));
          d_wr = 1'($urandom_range(0, 1));
          d_addr = 16'($urandom);
          d_wdata = 16'($urandom);
        end
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1'b1;
        d_wr = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom);
        d_wdata = 16'($urandom);
      end
      rst_n = ($urandom_range(0, 399) != 0);
    end
    rst_n = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (10) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
